// File: rtl/qk_score_drain_if.sv
// Stream bundle between the QK^T matmul, the score drain and softmax.
// The slave view belongs to the drain; the master view belongs to its environment.
interface qk_score_drain_if #(
  parameter int WIDTH_OUT = 16,
  parameter int LANES     = 4
);
  logic                         in_strobe;
  logic [LANES*WIDTH_OUT-1:0]   in_word;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH_OUT-1:0]         out_data;
  logic                         out_last;
  logic                         hold_matmul;

  modport master (
    output in_strobe, in_word, out_ready,
    input  out_valid, out_data, out_last, hold_matmul
  );

  modport slave (
    input  in_strobe, in_word, out_ready,
    output out_valid, out_data, out_last, hold_matmul
  );
endinterface

// File: rtl/qk_score_drain.sv
// Drain for the Qn x Kn^T matmul: buffers captured result words, scales each lane by
// 2^-SHIFT with round-half-up and serialises the scores onto a valid/ready stream.
module qk_score_drain #(
  parameter int WIDTH_OUT      = 16,
  parameter int FRAC_WIDTH_OUT = 8,
  parameter int LANES          = 4,
  parameter int SHIFT          = 4,
  parameter int ROW_LEN        = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  qk_score_drain_if.slave bus,
  output logic            overflow,
  output logic            busy
);
  localparam int WORD_W = LANES * WIDTH_OUT;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [WIDTH_OUT:0] RND = (WIDTH_OUT + 1)'(1) << (SHIFT - 1);

  if (SHIFT < 1 || SHIFT > WIDTH_OUT - 1) begin : g_bad_shift
    $error("qk_score_drain: SHIFT must lie in 1..WIDTH_OUT-1");
  end
  if (ROW_LEN % LANES != 0) begin : g_bad_row
    $error("qk_score_drain: ROW_LEN must be a multiple of LANES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("qk_score_drain: FIFO_DEPTH must be a power of two >= 2");
  end
  if (FRAC_WIDTH_OUT > WIDTH_OUT) begin : g_bad_frac
    $error("qk_score_drain: FRAC_WIDTH_OUT exceeds WIDTH_OUT");
  end

  typedef enum logic {IDLE, STREAM} state_e;

  // Sign-extend one bit so the rounding offset can never wrap.
  function automatic logic signed [WIDTH_OUT-1:0] scale(input logic signed [WIDTH_OUT-1:0] x);
    logic signed [WIDTH_OUT:0] s;
    s = {x[WIDTH_OUT-1], x} + RND;
    return WIDTH_OUT'(s >>> SHIFT);
  endfunction

  state_e                       state_q, state_d;
  logic [WORD_W-1:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [LW-1:0]                lane_cnt_q, lane_cnt_d;
  logic [RW-1:0]                row_cnt_q, row_cnt_d;
  logic                         out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [WIDTH_OUT-1:0]  out_data_q, out_data_d;
  logic                         hold_q, hold_d, overflow_q, overflow_d;

  logic [WORD_W-1:0]            head_word;
  logic signed [WIDTH_OUT-1:0]  lane_x;
  logic                         lane_last, row_last, load, pop, full, wr_en;

  always_comb begin
    head_word = mem_q[rd_ptr_q];
    lane_x    = head_word[int'(lane_cnt_q)*WIDTH_OUT +: WIDTH_OUT];
    lane_last = (lane_cnt_q == LW'(LANES - 1));
    row_last  = (row_cnt_q == RW'(ROW_LEN - 1));
    // The output register refills whenever it is empty or its element is being taken.
    load      = (state_q == STREAM) && (!out_valid_q || bus.out_ready);
    pop       = load && lane_last;
    full      = (count_q == CW'(FIFO_DEPTH));
    wr_en     = bus.in_strobe && (!full || pop) && !clear;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    lane_cnt_d  = lane_cnt_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    hold_d      = hold_q;
    overflow_d  = overflow_q;
    if (clear) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      lane_cnt_d  = '0;
      row_cnt_d   = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      hold_d      = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
      if (bus.in_strobe && !wr_en) overflow_d = 1'b1;
      if (load) begin
        out_valid_d = 1'b1;
        out_data_d  = scale(lane_x);
        out_last_d  = row_last;
        lane_cnt_d  = lane_last ? '0 : lane_cnt_q + LW'(1);
        row_cnt_d   = row_last  ? '0 : row_cnt_q + RW'(1);
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      state_d = (count_d != '0) ? STREAM : IDLE;
      hold_d  = (count_d >= CW'(FIFO_DEPTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lane_cnt_q  <= '0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      hold_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lane_cnt_q  <= lane_cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      hold_q      <= hold_d;
      overflow_q  <= overflow_d;
    end
  end

  // Word storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.in_word;
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.hold_matmul = hold_q;
  assign overflow        = overflow_q;
  assign busy            = (count_q != '0) || out_valid_q;
endmodule

// File: tb/tb_qk_score_drain.sv
// Bench for qk_score_drain: directed scenarios plus a randomized stream scored against
// a queue model of the expected scaled, row-tagged elements.
module tb_qk_score_drain;
  logic clk = 1'b0;
  logic rst_n, clear, overflow, busy;
  int   checks = 0;
  int   errors = 0;

  qk_score_drain_if #(.WIDTH_OUT(16), .LANES(4)) bus ();

  qk_score_drain dut (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus.slave),
                      .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  // Observations collected by the driver; scenarios compare these themselves.
  logic [15:0] got_data[$];
  logic        got_last[$];
  logic        s_valid[$], s_ready[$], s_hold[$], s_last[$];
  logic [15:0] s_data[$];

  // Reference: expected elements in order, with row position counted per element.
  logic [15:0] exp_data[$];
  logic        exp_last[$];
  int          exp_row;

  function automatic logic [15:0] scale_ref(input logic [15:0] x);
    int v, n, q;
    v = int'($signed(x));
    n = v + 8;
    if (n >= 0) q = n / 16;
    else        q = -((-n + 15) / 16);
    return 16'(q);
  endfunction

  task automatic model_reset();
    exp_data.delete(); exp_last.delete(); exp_row = 0;
    got_data.delete(); got_last.delete();
    s_valid.delete(); s_ready.delete(); s_hold.delete(); s_last.delete(); s_data.delete();
  endtask

  task automatic model_push(input logic [63:0] w);
    for (int l = 0; l < 4; l++) begin
      exp_data.push_back(scale_ref(w[16*l +: 16]));
      exp_last.push_back(exp_row == 15);
      exp_row = (exp_row + 1) % 16;
    end
  endtask

  function automatic logic [63:0] rand_word();
    logic [15:0] edges [6];
    logic [63:0] w;
    edges = '{16'h8000, 16'h7FFF, 16'hFFF8, 16'hFFF7, 16'h0008, 16'h0007};
    for (int l = 0; l < 4; l++)
      w[16*l +: 16] = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
    return w;
  endfunction

  // One clock: drive at posedge+1, observe at negedge, return at next posedge+1.
  task automatic step(input logic clr, input logic strb, input logic [63:0] w, input logic rdy);
    clear = clr; bus.in_strobe = strb; bus.in_word = w; bus.out_ready = rdy;
    @(negedge clk);
    s_valid.push_back(bus.out_valid); s_ready.push_back(rdy); s_hold.push_back(bus.hold_matmul);
    s_data.push_back(bus.out_data);   s_last.push_back(bus.out_last);
    if (bus.out_valid && rdy) begin
      got_data.push_back(bus.out_data); got_last.push_back(bus.out_last);
    end
    @(posedge clk); #1;
    clear = 1'b0; bus.in_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    obs = {bus.out_valid, bus.out_last, bus.hold_matmul, overflow, busy, |bus.out_data};
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b want 000000", obs); end
    checks++;
    if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.out_data); end
  endtask

  task automatic test_single();
    logic [15:0] lit [4];
    lit = '{16'h0002, 16'hFFFF, 16'h0010, 16'h0010};
    model_reset(); step(1'b1, 1'b0, '0, 1'b1); model_reset();
    step(1'b0, 1'b1, 64'h0100_00F8_FFF7_0018, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({s_valid[1], s_valid[2]} !== 2'b01) begin
      errors++; $display("FAIL single_latency: got valid %b%b at cycles 1,2 want 01", s_valid[1], s_valid[2]);
    end
    checks++;
    if (got_data.size() !== 4) begin errors++; $display("FAIL single_count: got %0d want 4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== lit[i] || got_last[i] !== 1'b0) begin
        errors++; $display("FAIL single_elem%0d: got %h/%b want %h/0", i, got_data[i], got_last[i], lit[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    model_reset(); step(1'b1, 1'b0, '0, 1'b1); model_reset();
    for (int i = 0; i < 4; i++) begin w = rand_word(); model_push(w); step(1'b0, 1'b1, w, 1'b1); end
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (got_data.size() !== 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", got_data.size()); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if ({s_hold[2], s_hold[3]} !== 2'b01) begin
      errors++; $display("FAIL b2b_hold: got %b%b after 2,3 entries want 01", s_hold[2], s_hold[3]);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] w;
    model_reset(); step(1'b1, 1'b0, '0, 1'b1); model_reset();
    for (int i = 0; i < 5; i++) begin
      w = rand_word(); if (i < 4) model_push(w); step(1'b0, 1'b1, w, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 3; i < 8; i++) begin
      checks++;
      if (s_hold[i] !== 1'b1) begin errors++; $display("FAIL ovf_hold%0d: got %b want 1", i, s_hold[i]); end
    end
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (got_data.size() !== 16) begin errors++; $display("FAIL ovf_count: got %0d want 16", got_data.size()); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL ovf_beat%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_stall();
    logic [63:0] w;
    logic        pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    model_reset(); step(1'b1, 1'b0, '0, 1'b1); model_reset();
    for (int i = 0; i < 40; i++) begin
      w = rand_word();
      if (i < 3) model_push(w);
      step(1'b0, i < 3, w, pat[i % 4]);
    end
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++; $display("FAIL stall_count: got %0d want %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    for (int i = 0; i + 1 < s_valid.size(); i++) begin
      if (s_valid[i] && !s_ready[i]) begin
        checks++;
        if ({s_valid[i+1], s_data[i+1], s_last[i+1]} !== {1'b1, s_data[i], s_last[i]}) begin
          errors++; $display("FAIL stall_hold%0d: got %b/%h/%b want 1/%h/%b", i, s_valid[i+1], s_data[i+1], s_last[i+1], s_data[i], s_last[i]);
        end
      end
    end
  endtask

  task automatic test_clear();
    logic [63:0] w;
    model_reset(); step(1'b1, 1'b0, '0, 1'b1); model_reset();
    step(1'b0, 1'b1, rand_word(), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rand_word(), 1'b0);
    step(1'b1, 1'b1, rand_word(), 1'b1);
    checks++;
    if ({bus.out_valid, overflow, busy, bus.hold_matmul} !== 4'b0) begin
      errors++; $display("FAIL clear_state: got v%b o%b b%b h%b want all 0", bus.out_valid, overflow, busy, bus.hold_matmul);
    end
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (got_data.size() !== 0) begin errors++; $display("FAIL clear_discard: got %0d beats want 0", got_data.size()); end
    for (int i = 0; i < 4; i++) begin w = rand_word(); model_push(w); step(1'b0, 1'b1, w, 1'b1); end
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (got_data.size() !== 16) begin errors++; $display("FAIL clear_count: got %0d want 16", got_data.size()); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL clear_beat%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] w;
    model_reset(); step(1'b1, 1'b0, '0, 1'b1); model_reset();
    step(1'b0, 1'b1, rand_word(), 1'b1);
    step(1'b0, 1'b1, rand_word(), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.hold_matmul, overflow, busy, bus.out_data} !== 21'b0) begin
      errors++; $display("FAIL arst_outputs: got v%b l%b h%b o%b b%b d%h want all 0", bus.out_valid,
                         bus.out_last, bus.hold_matmul, overflow, busy, bus.out_data);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin w = rand_word(); model_push(w); step(1'b0, 1'b1, w, 1'b1); end
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (got_data.size() !== 16) begin errors++; $display("FAIL arst_count: got %0d want 16", got_data.size()); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL arst_beat%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] w;
    logic        s;
    model_reset(); step(1'b1, 1'b0, '0, 1'b1); model_reset();
    for (int i = 0; i < 400; i++) begin
      s = !bus.hold_matmul && ($urandom_range(0, 2) == 0);
      w = rand_word();
      if (s) model_push(w);
      step(1'b0, s, w, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL rand_beat%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if ({overflow, busy} !== 2'b00) begin errors++; $display("FAIL rand_idle: got o%b b%b want 00", overflow, busy); end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    bus.in_strobe = 1'b0; bus.in_word = '0; bus.out_ready = 1'b0;
    exp_row = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
